// File: rtl/ex_mem_skid_stage_if.sv
// EX->MEM beat channel: vld/rdy handshake plus the control and data fields of one beat.
interface ex_mem_skid_stage_if #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 5
);
   logic              vld;
   logic              rdy;
   logic [CTRL_W-1:0] ctrl;
   logic              zero;
   logic [RD_W-1:0]   rd;
   logic [DATA_W-1:0] adder_out;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] read_data2;

   modport master (output vld, ctrl, zero, rd, adder_out, alu_result, read_data2,
                   input  rdy);
   modport slave  (input  vld, ctrl, zero, rd, adder_out, alu_result, read_data2,
                   output rdy);
endinterface

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM valid/ready stage with a 2-entry skid buffer, flush and bubble gating; 1-cycle latency.
// Backpressure: in_rdy decodes registered occupancy only, so MEM stalls never reach EX combinationally.
module ex_mem_skid_stage #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   ex_mem_skid_stage_if.slave    in_if,
   ex_mem_skid_stage_if.master   out_if,
   output logic [1:0]            occ,
   output logic                  fwd_en,
   output logic [RD_W-1:0]       fwd_rd
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              zero;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] adder_out;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] read_data2;
   } beat_t;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e state_q, state_d;
   beat_t  head_q, head_d;
   beat_t  skid_q, skid_d;
   beat_t  in_beat;
   logic   out_vld;
   logic   in_rdy;
   logic   acc;
   logic   pop;

   assign in_beat.ctrl       = in_if.ctrl;
   assign in_beat.zero       = in_if.zero;
   assign in_beat.rd         = in_if.rd;
   assign in_beat.adder_out  = in_if.adder_out;
   assign in_beat.alu_result = in_if.alu_result;
   assign in_beat.read_data2 = in_if.read_data2;

   assign out_vld = (state_q != EMPTY);
   assign in_rdy  = (state_q != TWO);
   assign acc     = in_if.vld & in_rdy;
   assign pop     = out_vld & out_if.rdy;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         // A pop in this cycle is simply absorbed; nothing survives a flush.
         state_d     = EMPTY;
         head_d.ctrl = '0;
         head_d.zero = 1'b0;
         skid_d.ctrl = '0;
         skid_d.zero = 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_d = ONE;
                  head_d  = in_beat;
               end
            end
            ONE: begin
               if (acc && pop) begin
                  head_d = in_beat;
               end else if (acc) begin
                  state_d = TWO;
                  skid_d  = in_beat;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  state_d = ONE;
                  head_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   assign in_if.rdy = in_rdy;

   // Control and zero are gated so a bubble can never write memory or the register file.
   assign out_if.vld        = out_vld;
   assign out_if.ctrl       = out_vld ? head_q.ctrl : '0;
   assign out_if.zero       = out_vld & head_q.zero;
   assign out_if.rd         = head_q.rd;
   assign out_if.adder_out  = head_q.adder_out;
   assign out_if.alu_result = head_q.alu_result;
   assign out_if.read_data2 = head_q.read_data2;

   assign occ    = state_q;
   assign fwd_en = out_vld & head_q.ctrl[0] & (head_q.rd != '0);
   assign fwd_rd = head_q.rd;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage: queue model checked every cycle plus literal expectations.
module tb_ex_mem_skid_stage;
   localparam int DATA_W = 64;
   localparam int RD_W   = 5;
   localparam int CTRL_W = 5;

   typedef struct {
      logic [CTRL_W-1:0] ctrl;
      logic              zero;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] adder_out;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] read_data2;
   } beat_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   logic [1:0]      occ;
   logic            fwd_en;
   logic [RD_W-1:0] fwd_rd;

   int checks   = 0;
   int failures = 0;

   beat_t             model_q[$];
   logic [DATA_W-1:0] obs_q[$];

   ex_mem_skid_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) in_if ();
   ex_mem_skid_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) out_if ();

   ex_mem_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .in_if  (in_if),
      .out_if (out_if),
      .occ    (occ),
      .fwd_en (fwd_en),
      .fwd_rd (fwd_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a FIFO of at most two beats; flush empties it, pop before push.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_q.delete();
      end else if (flush) begin
         model_q.delete();
      end else begin
         automatic bit    m_pop = (model_q.size() > 0) && (out_if.rdy === 1'b1);
         automatic bit    m_acc = (in_if.vld === 1'b1) && (model_q.size() < 2);
         automatic beat_t b;
         b.ctrl       = in_if.ctrl;
         b.zero       = in_if.zero;
         b.rd         = in_if.rd;
         b.adder_out  = in_if.adder_out;
         b.alu_result = in_if.alu_result;
         b.read_data2 = in_if.read_data2;
         if (m_pop) void'(model_q.pop_front());
         if (m_acc) model_q.push_back(b);
      end
   end

   // Single compare process, mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         automatic int n = model_q.size();
         chk("occ", 64'(occ), 64'(n));
         chk("out_valid", 64'(out_if.vld), 64'(n != 0));
         chk("in_ready", 64'(in_if.rdy), 64'(n != 2));
         if (n != 0) begin
            chk("out_ctrl", 64'(out_if.ctrl), 64'(model_q[0].ctrl));
            chk("out_zero", 64'(out_if.zero), 64'(model_q[0].zero));
            chk("out_rd", 64'(out_if.rd), 64'(model_q[0].rd));
            chk("out_adder_out", out_if.adder_out, model_q[0].adder_out);
            chk("out_alu_result", out_if.alu_result, model_q[0].alu_result);
            chk("out_read_data2", out_if.read_data2, model_q[0].read_data2);
            chk("fwd_en", 64'(fwd_en),
                64'(model_q[0].ctrl[0] && (model_q[0].rd != 0)));
            chk("fwd_rd", 64'(fwd_rd), 64'(model_q[0].rd));
            if (out_if.vld === 1'b1 && out_if.rdy === 1'b1) obs_q.push_back(out_if.alu_result);
         end else begin
            chk("bubble_ctrl", 64'(out_if.ctrl), 64'd0);
            chk("bubble_zero", 64'(out_if.zero), 64'd0);
            chk("bubble_fwd_en", 64'(fwd_en), 64'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [4:0] ctrl, input logic zero, input logic [4:0] rd,
                        input logic [63:0] alu);
      in_if.vld        = 1'b1;
      in_if.ctrl       = ctrl;
      in_if.zero       = zero;
      in_if.rd         = rd;
      in_if.alu_result = alu;
      in_if.adder_out  = alu + 64'h100;
      in_if.read_data2 = ~alu;
   endtask

   // Holds the beat until the stage takes it, with a bounded wait.
   task automatic send(input logic [4:0] ctrl, input logic zero, input logic [4:0] rd,
                       input logic [63:0] alu);
      bit done = 0;
      drive(ctrl, zero, rd, alu);
      for (int i = 0; i < 20 && !done; i++) begin
         if (in_if.rdy === 1'b1) done = 1;
         tick();
      end
      if (!done) begin
         failures++;
         $display("FAIL send_timeout: beat %0h never accepted", alu);
      end
      in_if.vld = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      in_if.vld = 1'b0;
      in_if.ctrl = '0;
      in_if.zero = 1'b0;
      in_if.rd = '0;
      in_if.adder_out = '0;
      in_if.alu_result = '0;
      in_if.read_data2 = '0;
      out_if.rdy = 1'b0;

      // Reset state, and a beat presented under reset is ignored.
      tick();
      drive(5'b00001, 1'b1, 5'd4, 64'h99);
      tick();
      chk("rst_occ", 64'(occ), 64'd0);
      chk("rst_in_ready", 64'(in_if.rdy), 64'd1);
      chk("rst_out_valid", 64'(out_if.vld), 64'd0);
      chk("rst_alu_result", out_if.alu_result, 64'd0);
      chk("rst_fwd_en", 64'(fwd_en), 64'd0);
      in_if.vld = 1'b0;
      reset = 1'b0;
      tick();

      // Streaming at full throughput.
      out_if.rdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         send(5'b00001, 1'b0, 5'd7, 64'(k));
         chk("stream_alu", out_if.alu_result, 64'(k));
         chk("stream_occ", 64'(occ), 64'd1);
         chk("stream_fwd_en", 64'(fwd_en), 64'd1);
         chk("stream_fwd_rd", 64'(fwd_rd), 64'd7);
      end
      tick();
      chk("stream_drain_occ", 64'(occ), 64'd0);

      // Backpressure: A and B fill the stage, C waits in EX.
      out_if.rdy = 1'b0;
      obs_q.delete();
      send(5'b00001, 1'b0, 5'd2, 64'hA);
      send(5'b00001, 1'b0, 5'd2, 64'hB);
      drive(5'b00001, 1'b0, 5'd2, 64'hC);
      tick();
      tick();
      chk("bp_occ", 64'(occ), 64'd2);
      chk("bp_in_ready", 64'(in_if.rdy), 64'd0);
      chk("bp_head", out_if.alu_result, 64'hA);
      out_if.rdy = 1'b1;
      send(5'b00001, 1'b0, 5'd2, 64'hC);
      tick();
      chk("bp_obs_count", 64'(obs_q.size()), 64'd3);
      if (obs_q.size() == 3) begin
         chk("bp_obs0", obs_q[0], 64'hA);
         chk("bp_obs1", obs_q[1], 64'hB);
         chk("bp_obs2", obs_q[2], 64'hC);
      end

      // Flush with two MemWrite beats held and D presented.
      out_if.rdy = 1'b0;
      send(5'b01000, 1'b1, 5'd0, 64'h21);
      send(5'b01000, 1'b1, 5'd0, 64'h22);
      chk("fl_pre_occ", 64'(occ), 64'd2);
      obs_q.delete();
      flush = 1'b1;
      drive(5'b01000, 1'b0, 5'd5, 64'hD);
      tick();
      flush = 1'b0;
      in_if.vld = 1'b0;
      chk("fl_occ", 64'(occ), 64'd0);
      chk("fl_out_valid", 64'(out_if.vld), 64'd0);
      chk("fl_out_ctrl", 64'(out_if.ctrl), 64'd0);
      out_if.rdy = 1'b1;
      repeat (3) tick();
      chk("fl_no_d", 64'(obs_q.size()), 64'd0);

      // Bubble gating after an all-ones control beat drains.
      send(5'b11111, 1'b1, 5'd3, 64'h55);
      chk("bub_live_ctrl", 64'(out_if.ctrl), 64'h1f);
      chk("bub_live_zero", 64'(out_if.zero), 64'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bub_ctrl", 64'(out_if.ctrl), 64'd0);
         chk("bub_zero", 64'(out_if.zero), 64'd0);
         chk("bub_fwd_en", 64'(fwd_en), 64'd0);
      end

      // Register x0 is never forwarded.
      out_if.rdy = 1'b0;
      send(5'b00001, 1'b0, 5'd0, 64'h77);
      chk("x0_valid", 64'(out_if.vld), 64'd1);
      chk("x0_fwd_en", 64'(fwd_en), 64'd0);
      out_if.rdy = 1'b1;
      tick();

      // Asynchronous reset from a full stage, observed before any edge.
      out_if.rdy = 1'b0;
      send(5'b01001, 1'b1, 5'd9, 64'h31);
      send(5'b01001, 1'b1, 5'd9, 64'h32);
      chk("ar_pre_occ", 64'(occ), 64'd2);
      #1 reset = 1'b1;
      #1;
      chk("ar_occ", 64'(occ), 64'd0);
      chk("ar_out_valid", 64'(out_if.vld), 64'd0);
      chk("ar_out_ctrl", 64'(out_if.ctrl), 64'd0);
      chk("ar_in_ready", 64'(in_if.rdy), 64'd1);
      tick();
      reset = 1'b0;
      out_if.rdy = 1'b1;
      tick();
      chk("ar_post_occ", 64'(occ), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Parametrised successor to the plain EX/MEM pipeline register: a valid/ready pipeline stage with a 2-entry skid buffer, synchronous flush and bubble gating.
- Sits between the EX stage (ALU, branch adder) and the MEM stage (data memory, branch resolve).
- Lets MEM stall without combinationally back-propagating ready into EX.
- Exposes occupancy and a forwarding tap for the hazard unit.

Parameters:
- DATA_W, 64, width of adder_out, alu_result and read_data2.
- RD_W, 5, destination register index width.
- CTRL_W, 5, control vector width. Must be >= 5. Bit map: [0] RegWrite, [1] MemRead, [2] MemToReg, [3] MemWrite, [4] Branch. Bits [CTRL_W-1:5] pass through and are gated like the others.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held entries; incoming beat discarded
- in_valid  in  1  EX presents a beat
- in_ready  out  1  stage can accept; equals (occ != 2)
- in_ctrl  in  CTRL_W  control vector
- in_zero  in  1  ALU zero flag
- in_rd  in  RD_W  destination register
- in_adder_out  in  DATA_W  branch target
- in_alu_result  in  DATA_W  ALU result
- in_read_data2  in  DATA_W  store data
- out_valid  out  1  head entry valid to MEM
- out_ready  in  1  MEM consumes head
- out_ctrl  out  CTRL_W  head control; all zero when !out_valid
- out_zero  out  1  head zero flag; 0 when !out_valid
- out_rd, out_adder_out, out_alu_result, out_read_data2  out  RD_W/DATA_W  head data fields, ungated
- occ  out  2  entries held (0, 1 or 2)
- fwd_en  out  1  out_valid & out_ctrl[0] & (out_rd != 0)
- fwd_rd  out  RD_W  equals out_rd

Behaviour:
- Storage: a head entry (drives outputs) and a skid entry. State is EMPTY (occ=0), ONE (occ=1) or TWO (occ=2).
- Reset (async assert, released on clock): state EMPTY. All head and skid fields zero. Outputs all zero; in_ready=1. Beats presented while reset is high are ignored.
- acc = in_valid & in_ready. pop = out_valid & out_ready. Both are sampled at the rising edge.
- EMPTY:
  - acc -> ONE, head <= in.
  - out_valid=0; out_ready is ignored.
- ONE:
  - acc & pop -> ONE, head <= in (back-to-back, full throughput).
  - acc & !pop -> TWO, skid <= in.
  - !acc & pop -> EMPTY.
  - neither -> hold.
- TWO:
  - in_ready=0.
  - pop -> ONE, head <= skid.
  - else hold, with no field changes.
- Latency: a beat accepted at edge N appears at out_* after edge N with zero bubbles when the stage was EMPTY, or when it was ONE with pop.
- Ordering is strict FIFO; no beat is dropped or duplicated except on flush.
- Flush:
  - Has highest priority over acc and pop.
  - Next state EMPTY. Head and skid ctrl and zero are cleared to 0; data fields may hold stale values.
  - A beat presented in the flush cycle is discarded, even if in_ready=1.
  - A pop in the flush cycle still counts as consumed by MEM. The stage treats it identically to flush-only.
- Gating: out_ctrl and out_zero are forced to 0 whenever out_valid=0, so a bubble can never write memory or the register file.
- fwd_en only reflects the head entry; the skid entry is never forwarded.
- in_ready is a pure decode of registered state, with no combinational path from out_ready.

Test Plan:
- Reset mid-operation: fill to occ=2, assert reset asynchronously mid-cycle -> occ=0, out_valid=0, out_ctrl=0, in_ready=1 immediately without waiting for a clock edge.
- Streaming: out_ready=1, present alu_result 1,2,3,4 on consecutive cycles with in_ctrl=5'b00001, rd=7 -> out_alu_result 1,2,3,4 one cycle later, occ stays 1, fwd_en=1, fwd_rd=7.
- Backpressure: out_ready=0, send A=0xA, B=0xB, C=0xC -> A, B accepted, occ=2, in_ready=0, C held by EX; release out_ready -> outputs A, B, C in order, with no loss.
- Flush: occ=2 with MemWrite set in both entries, flush=1 with in_valid=1 (D=0xD) -> next cycle occ=0, out_valid=0, out_ctrl=0; D never appears at the outputs.
- Bubble gating: in_valid=0 for 3 cycles after a beat with in_ctrl=5'b11111 is popped -> out_ctrl=0, out_zero=0, fwd_en=0 each cycle.
- x0 filter: beat with RegWrite=1, rd=0 -> out_valid=1, fwd_en=0.
